// File: rtl/alarm_clock_multi.sv
// alarm_clock_multi: 24-hour timekeeper with N_ALARMS independently enabled
// alarm slots sharing one ring/snooze state machine, ring auto-timeout and
// snooze countdown.
// Optional feature macro: ALARM_SNOOZE_LIMIT_EN caps accepted snoozes per
// ring episode at MAX_SNOOZE; when undefined, snooze is unlimited.
module alarm_clock_multi #(
  parameter int unsigned CLK_HZ     = 10000000,
  parameter int unsigned N_ALARMS   = 4,
  parameter int unsigned SNOOZE_MIN = 5,
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned MAX_SNOOZE = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                time_we,
  input  logic [4:0]          time_hh,
  input  logic [5:0]          time_mm,
  input  logic                alarm_we,
  input  logic [2:0]          alarm_idx,
  input  logic                alarm_en,
  input  logic [4:0]          alarm_hh,
  input  logic [5:0]          alarm_mm,
  input  logic                snooze,
  input  logic                dismiss,
  output logic [4:0]          hh,
  output logic [5:0]          mm,
  output logic [5:0]          ss,
  output logic                sec_tick,
  output logic                ringing,
  output logic                snoozing,
  output logic [N_ALARMS-1:0] ring_mask
);

  localparam int unsigned PRE_W   = $clog2(CLK_HZ);
  localparam int unsigned RT_W    = $clog2(RING_SEC + 1);
  localparam int unsigned SNZ_MAX = SNOOZE_MIN * 60;
  localparam int unsigned SZ_W    = $clog2(SNZ_MAX + 1);

  // Elaboration-time sanity check on the parameter ranges
  if (CLK_HZ < 2 || N_ALARMS < 1 || N_ALARMS > 8 || SNOOZE_MIN < 1 ||
      SNOOZE_MIN > 30 || RING_SEC < 1 || RING_SEC > 255 || MAX_SNOOZE > 255) begin : g_param_check
    $error("alarm_clock_multi: parameter out of range");
  end

  typedef struct packed {
    logic       en;
    logic [4:0] hh;
    logic [5:0] mm;
  } slot_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RING   = 2'd1,
    S_SNOOZE = 2'd2
  } state_t;

  state_t              state;
  logic [PRE_W-1:0]    pre;
  logic [RT_W-1:0]     ring_t;
  logic [SZ_W-1:0]     snz_t;
  slot_t               slots [N_ALARMS];

  logic                load_ok_c;
  logic                alarm_ok_c;
  logic                tick_c;
  logic                snooze_ok_c;
  logic [4:0]          hh_n;
  logic [5:0]          mm_n;
  logic [5:0]          ss_n;
  logic [N_ALARMS-1:0] match_c;
  logic                any_match_c;

  // Write qualification, tick generation, next time of day and alarm match
  always_comb begin
    load_ok_c  = time_we && (time_hh <= 5'd23) && (time_mm <= 6'd59);
    alarm_ok_c = alarm_we && (32'(alarm_idx) < N_ALARMS) &&
                 (alarm_hh <= 5'd23) && (alarm_mm <= 6'd59);
    tick_c     = (pre == PRE_W'(CLK_HZ - 1)) && !load_ok_c;
    hh_n = hh;
    mm_n = mm;
    ss_n = ss + 6'd1;
    if (ss == 6'd59) begin
      ss_n = 6'd0;
      if (mm == 6'd59) begin
        mm_n = 6'd0;
        hh_n = (hh == 5'd23) ? 5'd0 : hh + 5'd1;
      end else begin
        mm_n = mm + 6'd1;
      end
    end
    match_c = '0;
    for (int i = 0; i < int'(N_ALARMS); i++) begin
      match_c[i] = tick_c && (ss == 6'd59) && slots[i].en &&
                   (slots[i].hh == hh_n) && (slots[i].mm == mm_n);
    end
    any_match_c = |match_c;
  end

  assign sec_tick = tick_c;

  // Prescaler and time-of-day registers; a valid load wins over a tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
      hh  <= 5'd0;
      mm  <= 6'd0;
      ss  <= 6'd0;
    end else if (load_ok_c) begin
      pre <= '0;
      hh  <= time_hh;
      mm  <= time_mm;
      ss  <= 6'd0;
    end else if (tick_c) begin
      pre <= '0;
      hh  <= hh_n;
      mm  <= mm_n;
      ss  <= ss_n;
    end else begin
      pre <= pre + PRE_W'(1);
    end
  end

  // Alarm slot storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(N_ALARMS); i++) begin
        slots[i] <= '0;
      end
    end else if (alarm_ok_c) begin
      for (int i = 0; i < int'(N_ALARMS); i++) begin
        if (alarm_idx == 3'(i)) begin
          slots[i] <= '{en: alarm_en, hh: alarm_hh, mm: alarm_mm};
        end
      end
    end
  end

`ifdef ALARM_SNOOZE_LIMIT_EN
  localparam int unsigned SC_W = (MAX_SNOOZE < 1) ? 1 : $clog2(MAX_SNOOZE + 1);
  logic [SC_W-1:0] snz_count;

  assign snooze_ok_c = snooze && (snz_count < SC_W'(MAX_SNOOZE));

  // Accepted-snooze counter; IDLE always precedes a fresh ring episode, so
  // holding it clear there covers entry from IDLE, dismiss and timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snz_count <= '0;
    end else if (state == S_IDLE) begin
      snz_count <= '0;
    end else if (state == S_RING && !dismiss && snooze_ok_c) begin
      snz_count <= snz_count + SC_W'(1);
    end
  end
`else
  assign snooze_ok_c = snooze;
`endif

  // Ring/snooze state machine with ring timeout and snooze countdown
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      ringing   <= 1'b0;
      snoozing  <= 1'b0;
      ring_mask <= '0;
      ring_t    <= '0;
      snz_t     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_match_c) begin
            state     <= S_RING;
            ringing   <= 1'b1;
            ring_mask <= match_c;
            ring_t    <= '0;
          end
        end
        S_RING: begin
          if (dismiss) begin
            state     <= S_IDLE;
            ringing   <= 1'b0;
            ring_mask <= '0;
            ring_t    <= '0;
          end else if (snooze_ok_c) begin
            state     <= S_SNOOZE;
            ringing   <= 1'b0;
            snoozing  <= 1'b1;
            ring_mask <= ring_mask | match_c;
            snz_t     <= SZ_W'(SNZ_MAX);
          end else if (any_match_c) begin
            ring_mask <= ring_mask | match_c;
            ring_t    <= '0;
          end else if (tick_c) begin
            if (ring_t == RT_W'(RING_SEC - 1)) begin
              state     <= S_IDLE;
              ringing   <= 1'b0;
              ring_mask <= '0;
              ring_t    <= '0;
            end else begin
              ring_t <= ring_t + RT_W'(1);
            end
          end
        end
        S_SNOOZE: begin
          if (dismiss) begin
            state     <= S_IDLE;
            snoozing  <= 1'b0;
            ring_mask <= '0;
            snz_t     <= '0;
          end else if (any_match_c) begin
            state     <= S_RING;
            ringing   <= 1'b1;
            snoozing  <= 1'b0;
            ring_mask <= ring_mask | match_c;
            ring_t    <= '0;
            snz_t     <= '0;
          end else if (tick_c) begin
            if (snz_t <= SZ_W'(1)) begin
              state    <= S_RING;
              ringing  <= 1'b1;
              snoozing <= 1'b0;
              ring_t   <= '0;
              snz_t    <= '0;
            end else begin
              snz_t <= snz_t - SZ_W'(1);
            end
          end
        end
        default: begin
          state    <= S_IDLE;
          ringing  <= 1'b0;
          snoozing <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_clock_multi.sv
// Directed bench for alarm_clock_multi with CLK_HZ=4, SNOOZE_MIN=1, RING_SEC=10.
module tb_alarm_clock_multi;

  localparam int unsigned CLK_HZ     = 4;
  localparam int unsigned N_ALARMS   = 4;
  localparam int unsigned SNOOZE_MIN = 1;
  localparam int unsigned RING_SEC   = 10;
  localparam int unsigned MAX_SNOOZE = 3;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                time_we = 1'b0;
  logic [4:0]          time_hh = '0;
  logic [5:0]          time_mm = '0;
  logic                alarm_we = 1'b0;
  logic [2:0]          alarm_idx = '0;
  logic                alarm_en = 1'b0;
  logic [4:0]          alarm_hh = '0;
  logic [5:0]          alarm_mm = '0;
  logic                snooze = 1'b0;
  logic                dismiss = 1'b0;
  logic [4:0]          hh;
  logic [5:0]          mm;
  logic [5:0]          ss;
  logic                sec_tick;
  logic                ringing;
  logic                snoozing;
  logic [N_ALARMS-1:0] ring_mask;

  int total = 0;
  int bad   = 0;

  alarm_clock_multi #(
    .CLK_HZ(CLK_HZ), .N_ALARMS(N_ALARMS), .SNOOZE_MIN(SNOOZE_MIN),
    .RING_SEC(RING_SEC), .MAX_SNOOZE(MAX_SNOOZE)
  ) dut (
    .clk(clk), .rst(rst), .time_we(time_we), .time_hh(time_hh), .time_mm(time_mm),
    .alarm_we(alarm_we), .alarm_idx(alarm_idx), .alarm_en(alarm_en),
    .alarm_hh(alarm_hh), .alarm_mm(alarm_mm), .snooze(snooze), .dismiss(dismiss),
    .hh(hh), .mm(mm), .ss(ss), .sec_tick(sec_tick), .ringing(ringing),
    .snoozing(snoozing), .ring_mask(ring_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_time(input string tag, input int h, input int m, input int s);
    check({tag, ".hh"}, 32'(hh), 32'(h));
    check({tag, ".mm"}, 32'(mm), 32'(m));
    check({tag, ".ss"}, 32'(ss), 32'(s));
  endtask

  // Advance through n tick edges; each wait is bounded
  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      int w = 0;
      while (!sec_tick && w < 2 * CLK_HZ) begin
        step();
        w++;
      end
      if (!sec_tick) check("tick_timeout", 32'(sec_tick), 32'd1);
      step();
    end
  endtask

  task automatic load_time(input int h, input int m);
    time_we = 1'b1;
    time_hh = 5'(h);
    time_mm = 6'(m);
    step();
    time_we = 1'b0;
  endtask

  task automatic set_alarm(input int idx, input bit en, input int h, input int m);
    alarm_we  = 1'b1;
    alarm_idx = 3'(idx);
    alarm_en  = en;
    alarm_hh  = 5'(h);
    alarm_mm  = 6'(m);
    step();
    alarm_we  = 1'b0;
  endtask

  task automatic pulse(input bit s, input bit d);
    snooze  = s;
    dismiss = d;
    step();
    snooze  = 1'b0;
    dismiss = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit exp_ring;
    repeat (2) @(posedge clk);
    #1;
    check_time("reset", 0, 0, 0);
    check("reset.ringing", 32'(ringing), 0);
    check("reset.snoozing", 32'(snoozing), 0);
    check("reset.mask", 32'(ring_mask), 0);
    rst = 1'b0;

    // Prescaler: tick on cycles 3, 7, 11, 15
    for (int c = 0; c < 16; c++) begin
      check($sformatf("tick_cycle%0d", c), 32'(sec_tick), 32'((c % 4) == 3));
      step();
    end
    check_time("after16", 0, 0, 4);

    // Rollover 23:59 -> 00:00:00
    load_time(23, 59);
    check_time("load2359", 23, 59, 0);
    run_ticks(60);
    check_time("rollover", 0, 0, 0);
    check("no_ring_idle", 32'(ringing), 0);

    // Load on a tick cycle suppresses the tick
    repeat (3) step();
    check("tick_before_load", 32'(sec_tick), 1);
    time_we = 1'b1; time_hh = 5'd12; time_mm = 6'd34;
    #1;
    check("tick_suppressed", 32'(sec_tick), 0);
    step();
    time_we = 1'b0;
    check_time("load1234", 12, 34, 0);
    load_time(24, 10);
    check_time("bad_hh", 12, 34, 0);
    load_time(5, 60);
    check_time("bad_mm", 12, 34, 0);

    // Single alarm ring and auto-timeout
    set_alarm(2, 1'b1, 7, 30);
    load_time(7, 29);
    run_ticks(59);
    check_time("pre_alarm", 7, 29, 59);
    check("pre_alarm.ringing", 32'(ringing), 0);
    run_ticks(1);
    check_time("alarm", 7, 30, 0);
    check("alarm.ringing", 32'(ringing), 1);
    check("alarm.mask", 32'(ring_mask), 32'b0100);
    run_ticks(9);
    check("ring9.ringing", 32'(ringing), 1);
    run_ticks(1);
    check("timeout.ringing", 32'(ringing), 0);
    check("timeout.mask", 32'(ring_mask), 0);

    // Snooze countdown then snooze+dismiss together
    load_time(7, 29);
    run_ticks(60);
    check("ring2.ringing", 32'(ringing), 1);
    pulse(1'b1, 1'b0);
    check("snz.snoozing", 32'(snoozing), 1);
    check("snz.ringing", 32'(ringing), 0);
    check("snz.mask", 32'(ring_mask), 32'b0100);
    run_ticks(59);
    check("snz59.snoozing", 32'(snoozing), 1);
    run_ticks(1);
    check("snz60.ringing", 32'(ringing), 1);
    check("snz60.snoozing", 32'(snoozing), 0);
    pulse(1'b1, 1'b1);
    check("both.ringing", 32'(ringing), 0);
    check("both.snoozing", 32'(snoozing), 0);
    check("both.mask", 32'(ring_mask), 0);
    pulse(1'b1, 1'b0);
    check("idle_snooze_ignored", 32'(snoozing), 0);

    // Two slots at once, third slot matches while snoozing
    set_alarm(2, 1'b0, 7, 30);
    set_alarm(0, 1'b1, 6, 0);
    set_alarm(3, 1'b1, 6, 0);
    set_alarm(4, 1'b1, 5, 59);
    set_alarm(0, 1'b1, 24, 0);
    load_time(5, 59);
    run_ticks(60);
    check("dual.ringing", 32'(ringing), 1);
    check("dual.mask", 32'(ring_mask), 32'b1001);
    pulse(1'b1, 1'b0);
    set_alarm(1, 1'b1, 6, 1);
    run_ticks(59);
    check_time("dual59", 6, 0, 59);
    check("dual59.snoozing", 32'(snoozing), 1);
    run_ticks(1);
    check("slot1.ringing", 32'(ringing), 1);
    check("slot1.mask", 32'(ring_mask), 32'b1011);
    pulse(1'b0, 1'b1);
    check("dismiss.mask", 32'(ring_mask), 0);
    check("dismiss.ringing", 32'(ringing), 0);

    // Snooze limit behaviour
    set_alarm(1, 1'b0, 6, 1);
    set_alarm(3, 1'b0, 6, 0);
    set_alarm(0, 1'b1, 10, 0);
    load_time(9, 59);
    run_ticks(60);
    check("lim.ringing", 32'(ringing), 1);
    check("lim.mask", 32'(ring_mask), 32'b0001);
    for (int k = 0; k < 3; k++) begin
      pulse(1'b1, 1'b0);
      check($sformatf("lim_snz%0d", k), 32'(snoozing), 1);
      run_ticks(60);
      check($sformatf("lim_ring%0d", k), 32'(ringing), 1);
    end
`ifdef ALARM_SNOOZE_LIMIT_EN
    exp_ring = 1'b1;
`else
    exp_ring = 1'b0;
`endif
    pulse(1'b1, 1'b0);
    check("snz4.ringing", 32'(ringing), 32'(exp_ring));
    check("snz4.snoozing", 32'(snoozing), 32'(!exp_ring));

    // Asynchronous reset mid-episode
    #2;
    rst = 1'b1;
    #1;
    check("arst.ringing", 32'(ringing), 0);
    check("arst.snoozing", 32'(snoozing), 0);
    check("arst.mask", 32'(ring_mask), 0);
    check_time("arst", 0, 0, 0);
    step();
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
